// File: rtl/traffic_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_ctrl
//   Frame-paced intersection controller feeding the 640x480 VGA renderer.
//   A one-cycle frame_tick is derived from the falling edge of vsync; on each
//   tick (unless paused) the light FSM phase timer and the east-west car
//   position advance. The car stops at the EW stop line unless EW is green.
//
// Ports
//   dclk       in   pixel clock (shared with VGA timing)
//   clr_n      in   asynchronous active-low reset
//   vsync      in   active-low vertical sync, dclk domain
//   sensor_ew  in   car waiting on EW approach (only used in NS_GREEN)
//   pause      in   freezes phase timer and car while high
//   frame_tick out  one-cycle pulse per frame
//   ns_light   out  00 red, 01 yellow, 10 green
//   ew_light   out  same encoding as ns_light
//   car_x      out  left edge of the EW car in active-video pixels
// ---------------------------------------------------------------------------
module traffic_ctrl #(
    parameter int unsigned GREEN_FRAMES  = 300,
    parameter int unsigned MIN_GREEN     = 120,
    parameter int unsigned YELLOW_FRAMES = 120,
    parameter int unsigned ALLRED_FRAMES = 60,
    parameter int unsigned CAR_W         = 60,
    parameter int unsigned CAR_STEP      = 2,
    parameter int unsigned STOP_X        = 200,
    parameter int unsigned X_MAX         = 639
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       vsync,
    input  logic       sensor_ew,
    input  logic       pause,
    output logic       frame_tick,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic [9:0] car_x
);

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    // Resting position of the car's left edge when its front is at the line.
    localparam logic [9:0] STOP_POS = 10'(STOP_X - CAR_W);

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        ALLRED_A,
        EW_GREEN,
        EW_YELLOW,
        ALLRED_B
    } state_t;

    logic       vsync_q;
    logic       frame_tick_q;
    state_t     state_q;
    state_t     state_d;
    logic [9:0] timer_q;
    logic [9:0] car_x_q;
    logic [9:0] car_x_d;
    logic [1:0] ns_light_q;
    logic [1:0] ew_light_q;
    logic [9:0] last_frame;
    logic       phase_done;
    logic       step;
    logic [10:0] car_nxt;

    // Light pair {ns, ew} shown while in a given state.
    function automatic logic [3:0] lights_of(input state_t s);
        logic [3:0] l;
        case (s)
            NS_GREEN:  l = {LT_GREEN,  LT_RED};
            NS_YELLOW: l = {LT_YELLOW, LT_RED};
            EW_GREEN:  l = {LT_RED,    LT_GREEN};
            EW_YELLOW: l = {LT_RED,    LT_YELLOW};
            default:   l = {LT_RED,    LT_RED};
        endcase
        return l;
    endfunction

    assign step = frame_tick_q & ~pause;

    // Timer value on which the current state ends.
    always_comb begin
        last_frame = 10'(ALLRED_FRAMES - 1);
        case (state_q)
            NS_GREEN, EW_GREEN:   last_frame = 10'(GREEN_FRAMES - 1);
            NS_YELLOW, EW_YELLOW: last_frame = 10'(YELLOW_FRAMES - 1);
            default:              last_frame = 10'(ALLRED_FRAMES - 1);
        endcase
    end

    assign phase_done = (timer_q == last_frame) ||
                        ((state_q == NS_GREEN) && sensor_ew &&
                         (timer_q >= 10'(MIN_GREEN - 1)));

    always_comb begin
        state_d = NS_GREEN;
        case (state_q)
            NS_GREEN:  state_d = NS_YELLOW;
            NS_YELLOW: state_d = ALLRED_A;
            ALLRED_A:  state_d = EW_GREEN;
            EW_GREEN:  state_d = EW_YELLOW;
            EW_YELLOW: state_d = ALLRED_B;
            default:   state_d = NS_GREEN;
        endcase
    end

    // Car decision uses the registered light, i.e. the light before this
    // tick's state change. The clamp only applies to a car still behind the
    // line; one already past it keeps driving through.
    always_comb begin
        car_nxt = {1'b0, car_x_q} + 11'(CAR_STEP);
        car_x_d = car_nxt[9:0];
        if ((ew_light_q != LT_GREEN) && (car_x_q <= STOP_POS) &&
            (car_nxt > {1'b0, STOP_POS})) begin
            car_x_d = STOP_POS;
        end else if (car_nxt > 11'(X_MAX)) begin
            car_x_d = 10'd0;
        end
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            state_q      <= NS_GREEN;
            timer_q      <= 10'd0;
            car_x_q      <= 10'd0;
            ns_light_q   <= LT_GREEN;
            ew_light_q   <= LT_RED;
        end else begin
            vsync_q      <= vsync;
            frame_tick_q <= vsync_q & ~vsync;
            if (step) begin
                car_x_q <= car_x_d;
                if (phase_done) begin
                    state_q                  <= state_d;
                    timer_q                  <= 10'd0;
                    {ns_light_q, ew_light_q} <= lights_of(state_d);
                end else begin
                    timer_q <= timer_q + 10'd1;
                end
            end
        end
    end

    assign frame_tick = frame_tick_q;
    assign ns_light   = ns_light_q;
    assign ew_light   = ew_light_q;
    assign car_x      = car_x_q;

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Frame-paced traffic-intersection controller sitting directly upstream of the 640x480 VGA renderer. It derives a once-per-frame tick from the renderer's vsync and runs the north-south/east-west light state machine on that tick. It also advances the east-west car position, which stops at the stop line whenever the east-west light is not green. Its light codes and car_x feed the renderer's drawing logic in place of a free-running animation clock.

## Interface
- GREEN_FRAMES, 300: maximum green duration in frames (1..1023)
- MIN_GREEN, 120: minimum NS green before a sensor request may cut it short (1..GREEN_FRAMES)
- YELLOW_FRAMES, 120: yellow duration in frames (1..1023)
- ALLRED_FRAMES, 60: all-red clearance duration in frames (1..1023)
- CAR_W, 60: car width in pixels
- CAR_STEP, 2: pixels advanced per frame (1..15)
- STOP_X, 200: x coordinate of the EW stop line; car front never crosses it unless the EW light is green
- X_MAX, 639: last visible column; car wraps to 0 beyond it
- dclk  in  1  pixel clock, 25 MHz, shared with the VGA timing
- clr_n  in  1  asynchronous active-low reset
- vsync  in  1  active-low vertical sync from the VGA timing generator, same dclk domain
- sensor_ew  in  1  car waiting on EW approach; sampled only on frame_tick
- pause  in  1  freezes the phase timer and car while high
- frame_tick  out  1  one-cycle pulse per frame
- ns_light  out  2  00 red, 01 yellow, 10 green (11 never driven)
- ew_light  out  2  same encoding as ns_light
- car_x  out  10  left edge of the EW car, in active-video pixels

## Operation
- Edge detect: vsync_q <= vsync every cycle, reset value 1. frame_tick <= vsync_q & ~vsync, reset value 0.
- States: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, in a fixed cyclic order (ALLRED_B -> NS_GREEN).
- Lights per state:
  - NS_GREEN: ns=10, ew=00
  - NS_YELLOW: ns=01, ew=00
  - ALLRED_A and ALLRED_B: both 00
  - EW_GREEN: ns=00, ew=10
  - EW_YELLOW: ns=00, ew=01
- Phase timer: 10 bits, counts frames spent in the current state. It advances only on frame_tick & ~pause.
- Exit conditions:
  - Greens exit when timer == GREEN_FRAMES-1. NS_GREEN also exits early when sensor_ew=1 and timer >= MIN_GREEN-1.
  - Yellows exit when timer == YELLOW_FRAMES-1.
  - All-reds exit when timer == ALLRED_FRAMES-1.
  - On exit the timer clears to 0 and the state advances. Otherwise the timer increments.
- Car, evaluated on frame_tick & ~pause, with nxt = car_x + CAR_STEP (11-bit):
  - If ew_light != 10, car_x <= STOP_X-CAR_W, and nxt > STOP_X-CAR_W: car_x <= STOP_X-CAR_W (clamp at the stop line).
  - Else if nxt > X_MAX: car_x <= 0.
  - Else: car_x <= nxt.
- The car decision uses the registered ew_light value from before the same-edge state update.
- pause does not gate frame_tick or the edge detector.

## Timing
- Reset (clr_n low, asynchronous):
  - state=NS_GREEN, timer=0, car_x=0
  - ns_light=10, ew_light=00
  - frame_tick=0, vsync_q=1
- frame_tick is high for exactly the one cycle after the first dclk edge that samples vsync=0 following a sample of 1. vsync held low for any length yields one tick.
- State, timer, lights and car_x all update on the dclk edge at which frame_tick=1. Lights are registered together with state, so there is no decode glitch.
- A state lasting N frames spans N frame_ticks. A full cycle with no sensor input is 2*(GREEN+YELLOW+ALLRED) frames.
- When a light change and a car step fall on the same tick, the car sees the old light. A car at the stop line therefore moves one frame after EW turns green.
- clr_n asserted mid-phase returns everything to reset values immediately. The first tick after release counts as frame 0 of NS_GREEN.
- sensor_ew outside NS_GREEN is ignored and is not latched.

## Test plan
- Reset/idle: clr_n=0 then released with vsync held 1 for 10000 cycles -> ns_light=10, ew_light=00, car_x=0, frame_tick never asserts.
- Full cycle: GREEN=4, YELLOW=2, ALLRED=1, vsync pulsing every 100 cycles, sensor_ew=0 -> states in order with dwell of 4,2,1,4,2,1 ticks; NS_GREEN re-entered on tick 14.
- Sensor early exit: MIN_GREEN=2, GREEN=8, sensor_ew=1 from tick 0 -> NS_YELLOW entered on tick 2. With sensor_ew=1 first at tick 5 -> NS_YELLOW on tick 6.
- Stop line: defaults, EW red -> car_x steps 0,2,...,140 and holds at 140. It resumes at 142 on the tick after ew_light becomes 10. An odd CAR_STEP=3 clamps 138 -> 140.
- Wrap: car_x=638 with EW green, CAR_STEP=2 -> next tick car_x=0.
- Pause/reset mid-op: pause=1 for 5 ticks -> frame_tick still pulses 5 times, timer and car_x unchanged. clr_n pulsed low in EW_YELLOW -> immediately NS_GREEN, car_x=0.
